// File: rtl/ct_spsram_512x144_ctrl.sv
`default_nettype none
// ============================================================================
// ct_spsram_512x144_ctrl
//   Access controller for the 512x144 single-port SRAM macro: array zero-fill,
//   masked writes, in-order reads through a 2-entry credited response buffer.
//   Revision: 1.0
// ============================================================================
module ct_spsram_512x144_ctrl #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH = 144,
   parameter int unsigned INIT_EN    = 1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   typedef enum logic [1:0] {
      RST_WAIT = 2'd0,
      INIT     = 2'd1,
      RUN      = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
   logic                    rd_inflight_q, rd_inflight_d;
   logic [1:0]              buf_cnt_q, buf_cnt_d;
   logic                    wr_ptr_q, wr_ptr_d;
   logic                    rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0]   buf_q [2];
   logic [DATA_WIDTH-1:0]   buf_d [2];

   logic                    pop;
   logic                    push;
   logic [1:0]              credits;
   logic [1:0]              credits_after_pop;
   logic                    accept;
   logic                    wr_acc;
   logic                    rd_acc;

   // ------------------------------------------------------------------------
   // Sequencing FSM: one idle cycle after reset, optional zero sweep, then run
   // ------------------------------------------------------------------------
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q    <= RST_WAIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         RST_WAIT: begin
            init_cnt_d = '0;
            state_d    = (INIT_EN != 0) ? INIT : RUN;
         end
         INIT: begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = RST_WAIT;
         end
      endcase
   end

   assign init_done = (state_q == RUN);

   // ------------------------------------------------------------------------
   // Credit check: a read may only go out if, after this cycle's pop, fewer
   // than two reads are outstanding, so the buffer can never overflow.
   // ------------------------------------------------------------------------
   assign pop               = rsp_vld & rsp_rdy;
   assign credits           = buf_cnt_q + {1'b0, rd_inflight_q};
   assign credits_after_pop = credits - {1'b0, pop};
   assign req_rdy           = init_done & ((req_vld & req_wr) | (credits_after_pop < 2'd2));
   assign accept            = req_vld & req_rdy;
   assign wr_acc            = accept & req_wr;
   assign rd_acc            = accept & ~req_wr;

   // Macro pins are combinational from the request so access issues same-cycle
   always_comb begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = {DATA_WIDTH{1'b1}};
      sram_a    = '0;
      sram_d    = '0;
      if (state_q == INIT) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         sram_a    = init_cnt_q;
      end else if (wr_acc) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = ~req_wmask;
         sram_a    = req_addr;
         sram_d    = req_wdata;
      end else if (rd_acc) begin
         sram_cen  = 1'b0;
         sram_a    = req_addr;
      end
   end

   // ------------------------------------------------------------------------
   // Read return path: Q is captured only in the cycle after a read issue
   // ------------------------------------------------------------------------
   assign push = rd_inflight_q;

   always_comb begin
      rd_inflight_d = rd_acc;
      buf_d[0]      = buf_q[0];
      buf_d[1]      = buf_q[1];
      wr_ptr_d      = wr_ptr_q ^ push;
      rd_ptr_d      = rd_ptr_q ^ pop;
      buf_cnt_d     = buf_cnt_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
         buf_d[wr_ptr_q] = sram_q;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_inflight_q <= 1'b0;
         buf_cnt_q     <= '0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         buf_q[0]      <= '0;
         buf_q[1]      <= '0;
      end else begin
         rd_inflight_q <= rd_inflight_d;
         buf_cnt_q     <= buf_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         buf_q[0]      <= buf_d[0];
         buf_q[1]      <= buf_d[1];
      end
   end

   assign rsp_vld   = (buf_cnt_q != 2'd0);
   assign rsp_rdata = rsp_vld ? buf_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ct_spsram_512x144_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ct_spsram_512x144_ctrl
//   Randomized bench with a macro stub and a transaction-level reference model.
//   Revision: 1.0
// ============================================================================
module tb_ct_spsram_512x144_ctrl;

   localparam int AW = 9;
   localparam int DW = 144;
   localparam int INIT_CYCLES = 512;

   logic          clk;
   logic          cpurst_b;
   logic          req_vld;
   logic          req_rdy;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [DW-1:0] req_wmask;
   logic          rsp_vld;
   logic          rsp_rdy;
   logic [DW-1:0] rsp_rdata;
   logic          init_done;
   logic [AW-1:0] sram_a;
   logic          sram_cen;
   logic          sram_gwen;
   logic [DW-1:0] sram_wen;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q;

   ct_spsram_512x144_ctrl dut (
      .forever_cpuclk (clk),
      .cpurst_b       (cpurst_b),
      .req_vld        (req_vld),
      .req_rdy        (req_rdy),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_wmask      (req_wmask),
      .rsp_vld        (rsp_vld),
      .rsp_rdy        (rsp_rdy),
      .rsp_rdata      (rsp_rdata),
      .init_done      (init_done),
      .sram_a         (sram_a),
      .sram_cen       (sram_cen),
      .sram_gwen      (sram_gwen),
      .sram_wen       (sram_wen),
      .sram_d         (sram_d),
      .sram_q         (sram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rnd_wide();
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < 5; i++) r = (r << 32) | DW'($urandom());
      return r;
   endfunction

   // Macro stub: registered Q, garbage on Q whenever no read was performed
   logic [DW-1:0] macro_mem [512];
   initial begin
      for (int i = 0; i < 512; i++) macro_mem[i] = rnd_wide();
      sram_q = '0;
   end
   always @(posedge clk) begin
      if (!sram_cen && !sram_gwen)
         macro_mem[sram_a] <= (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      if (!sram_cen && sram_gwen) sram_q <= macro_mem[sram_a];
      else                        sram_q <= rnd_wide();
   end

   // Reference model: array contents plus queue of expected responses
   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic [DW-1:0] ref_mem [512];
   exp_t          exp_q [$];
   int            k;          // posedges since reset release
   int            hold;       // cycles to force rsp_rdy low
   int            rmode;      // 0/1 constant rsp_rdy, 2 random
   bit            last_acc;
   int            n_chk;
   int            n_err;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 512; i++) ref_mem[i] = '0;
      exp_q.delete();
      k = 0;
   endtask

   // One cycle: inputs are set by the caller just after a negedge
   task automatic step();
      bit            run, in_init, exp_vld, pop, exp_rdy, acc;
      logic          e_cen, e_gwen;
      logic [DW-1:0] e_wen, e_d;
      logic [AW-1:0] e_a;
      if (hold > 0) begin
         rsp_rdy = 1'b0;
         hold--;
      end else begin
         rsp_rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
      end
      #1;
      run     = (k >= INIT_CYCLES + 1);
      in_init = (k >= 1) && (k <= INIT_CYCLES);
      exp_vld = (exp_q.size() > 0) && (exp_q[0].due <= k);
      pop     = exp_vld && rsp_rdy;
      exp_rdy = run && ((req_vld && req_wr) || ((exp_q.size() - int'(pop)) < 2));
      acc     = req_vld && exp_rdy;
      check("init_done", DW'(init_done), DW'(run));
      check("req_rdy", DW'(req_rdy), DW'(exp_rdy));
      check("rsp_vld", DW'(rsp_vld), DW'(exp_vld));
      if (exp_vld) check("rsp_rdata", rsp_rdata, exp_q[0].data);

      e_cen = 1'b1; e_gwen = 1'b1; e_wen = '1; e_d = '0; e_a = '0;
      if (in_init) begin
         e_cen = 1'b0; e_gwen = 1'b0; e_wen = '0; e_a = AW'(k - 1);
      end else if (acc && req_wr) begin
         e_cen = 1'b0; e_gwen = 1'b0; e_wen = ~req_wmask; e_d = req_wdata; e_a = req_addr;
      end else if (acc) begin
         e_cen = 1'b0; e_a = req_addr;
      end
      check("sram_cen", DW'(sram_cen), DW'(e_cen));
      check("sram_gwen", DW'(sram_gwen), DW'(e_gwen));
      check("sram_wen", sram_wen, e_wen);
      check("sram_d", sram_d, e_d);
      check("sram_a", DW'(sram_a), DW'(e_a));

      if (pop) void'(exp_q.pop_front());
      if (acc) begin
         if (req_wr)
            ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
         else
            exp_q.push_back('{data: ref_mem[req_addr], due: k + 2});
      end
      last_acc = acc;
      @(posedge clk);
      k++;
      @(negedge clk);
   endtask

   task automatic idle_req();
      req_vld   = 1'b0;
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom());
      req_wdata = rnd_wide();
      req_wmask = rnd_wide();
   endtask

   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] m, output int waits);
      req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
      waits = 0;
      step();
      while (!last_acc && waits < 40) begin
         waits++;
         step();
      end
      if (!last_acc) check("issue_timeout", DW'(0), DW'(1));
      idle_req();
   endtask

   task automatic drain();
      int n;
      n = 0;
      idle_req();
      while (exp_q.size() > 0 && n < 40) begin
         step();
         n++;
      end
      check("drain_timeout", DW'(exp_q.size()), DW'(0));
   endtask

   task automatic run_init();
      req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(3);
      for (int i = 0; i <= INIT_CYCLES; i++) step();
      idle_req();
   endtask

   initial begin
      int            w;
      bit            pending;
      logic [DW-1:0] x;
      n_chk = 0; n_err = 0; hold = 0; rmode = 1; last_acc = 1'b0;
      cpurst_b = 1'b0; rsp_rdy = 1'b0;
      idle_req();
      req_vld = 1'b1;
      clear_model();
      repeat (3) @(negedge clk);
      check("rst_req_rdy", DW'(req_rdy), DW'(0));
      check("rst_rsp_vld", DW'(rsp_vld), DW'(0));
      check("rst_rsp_rdata", rsp_rdata, DW'(0));
      check("rst_init_done", DW'(init_done), DW'(0));
      check("rst_cen", DW'(sram_cen), DW'(1));
      check("rst_wen", sram_wen, {DW{1'b1}});
      check("rst_a", DW'(sram_a), DW'(0));
      cpurst_b = 1'b1;
      run_init();

      issue(1'b0, 9'h1FF, '0, '0, w);
      drain();
      issue(1'b1, 9'h005, {18{8'hA5}}, '1, w);
      issue(1'b0, 9'h005, '0, '0, w);
      drain();
      issue(1'b1, 9'h010, '1, '1, w);
      issue(1'b1, 9'h010, '0, {{72{1'b0}}, {72{1'b1}}}, w);
      issue(1'b0, 9'h010, '0, '0, w);
      drain();

      for (int i = 0; i < 8; i++) begin
         issue(1'b0, AW'(i), '0, '0, w);
         check("burst_no_stall", DW'(w), DW'(0));
      end
      drain();
      hold = 12;
      for (int i = 0; i < 8; i++) issue(1'b0, AW'(i), '0, '0, w);
      drain();

      x = rnd_wide();
      issue(1'b1, 9'h020, x, '1, w);
      issue(1'b0, 9'h020, '0, '0, w);
      drain();
      hold = 10;
      issue(1'b0, 9'h001, '0, '0, w);
      issue(1'b0, 9'h002, '0, '0, w);
      step(); step();
      issue(1'b1, 9'h021, rnd_wide(), rnd_wide(), w);
      check("wr_while_full", DW'(w), DW'(0));
      drain();

      rmode = 2; pending = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pending && $urandom_range(0, 3) != 0) begin
            req_vld = 1'b1; req_wr = 1'($urandom_range(0, 1));
            req_addr = AW'($urandom_range(0, 15));
            req_wdata = rnd_wide(); req_wmask = rnd_wide();
            pending = 1'b1;
         end
         step();
         if (last_acc) begin
            pending = 1'b0;
            idle_req();
         end
      end
      rmode = 1;
      drain();

      hold = 20;
      issue(1'b0, 9'h003, '0, '0, w);
      issue(1'b0, 9'h004, '0, '0, w);
      req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'h005;
      step(); step();
      #3 cpurst_b = 1'b0;
      #1;
      check("midrst_rsp_vld", DW'(rsp_vld), DW'(0));
      check("midrst_cen", DW'(sram_cen), DW'(1));
      check("midrst_init_done", DW'(init_done), DW'(0));
      check("midrst_req_rdy", DW'(req_rdy), DW'(0));
      clear_model();
      hold = 0;
      repeat (2) @(negedge clk);
      cpurst_b = 1'b1;
      run_init();
      for (int i = 0; i < 6; i++) step();
      issue(1'b0, 9'h003, '0, '0, w);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
